// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM state encoding and the canonical NOP.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_WAIT = 2'b01,
    ST_KILL = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_register.sv
// Fetch program counter: reset to RESET_PC, loadable on redirect, +4 on each consumed fetch.
module pc_register #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_load_pc,
  input  logic                  i_inc,
  output logic [DATA_WIDTH-1:0] o_pc
);

  logic [DATA_WIDTH-1:0] r_pc;

  // Load has priority over increment; increment wraps modulo 2^DATA_WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + DATA_WIDTH'(32'd4);
    end else begin
      r_pc <= r_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: REQ/WAIT/KILL request FSM feeding the IF/ID register.
// Optional MISALIGN_TRAP_EN adds fetch_misaligned and blocks fetches from unaligned redirect targets.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INSTRUCTION = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_en,
  input  logic [DATA_WIDTH-1:0]  redirect_pc,
  input  logic [INSTRUCTION-1:0] imem_rdata,
  input  logic                   imem_valid,
  output logic                   imem_req,
  output logic [DATA_WIDTH-1:0]  imem_addr,
  output logic [INSTRUCTION-1:0] instruction,
  output logic [DATA_WIDTH-1:0]  pc,
  output logic                   if_valid
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                   fetch_misaligned
`endif
);

  fetch_state_e           r_state;
  fetch_state_e           w_next_state;
  logic [INSTRUCTION-1:0] r_instruction;
  logic [DATA_WIDTH-1:0]  r_pc;
  logic                   r_if_valid;
  logic [DATA_WIDTH-1:0]  w_fetch_pc;
  logic [DATA_WIDTH-1:0]  w_load_value;
  logic                   w_load_pc;
  logic                   w_inc_pc;
  logic                   w_capture;
  logic                   w_clear;
  logic                   w_req;
  logic                   w_misaligned;

`ifdef MISALIGN_TRAP_EN
  logic r_misaligned;

  // Sticky trap flag, re-evaluated only when a redirect lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misaligned <= 1'b0;
    end else if (redirect_en) begin
      r_misaligned <= (redirect_pc[1:0] != 2'b00);
    end else begin
      r_misaligned <= r_misaligned;
    end
  end

  assign w_misaligned     = r_misaligned;
  assign fetch_misaligned = r_misaligned;
  assign w_load_value     = redirect_pc;
`else
  assign w_misaligned = 1'b0;
  assign w_load_value = redirect_pc & ~DATA_WIDTH'(32'd3);
`endif

  pc_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_register (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load_pc),
    .i_load_pc (w_load_value),
    .i_inc     (w_inc_pc),
    .o_pc      (w_fetch_pc)
  );

  // Redirect beats stall and imem_valid; stall freezes IF/ID; an unstalled cycle without a load empties IF/ID.
  always_comb begin
    w_next_state = r_state;
    w_load_pc    = 1'b0;
    w_inc_pc     = 1'b0;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    w_req        = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (redirect_en) begin
          w_load_pc    = 1'b1;
          w_clear      = 1'b1;
          w_next_state = ST_REQ;
        end else if (stall) begin
          w_next_state = ST_REQ;
        end else begin
          w_clear = 1'b1;
          if (!w_misaligned) begin
            w_req        = 1'b1;
            w_next_state = ST_WAIT;
          end else begin
            w_next_state = ST_REQ;
          end
        end
      end
      ST_WAIT: begin
        if (redirect_en) begin
          w_load_pc    = 1'b1;
          w_clear      = 1'b1;
          w_next_state = imem_valid ? ST_REQ : ST_KILL;
        end else if (stall) begin
          w_next_state = ST_WAIT;
        end else if (imem_valid) begin
          w_capture    = 1'b1;
          w_inc_pc     = 1'b1;
          w_next_state = ST_REQ;
        end else begin
          w_clear      = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_KILL: begin
        if (redirect_en) begin
          w_load_pc    = 1'b1;
          w_clear      = 1'b1;
          w_next_state = ST_KILL;
        end else begin
          w_clear      = !stall;
          w_next_state = imem_valid ? ST_REQ : ST_KILL;
        end
      end
      default: begin
        w_next_state = ST_REQ;
      end
    endcase
  end

  // FSM state and IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_REQ;
      r_instruction <= INSTRUCTION'(NOP_INSTR);
      r_pc          <= '0;
      r_if_valid    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_instruction <= imem_rdata;
        r_pc          <= w_fetch_pc;
        r_if_valid    <= 1'b1;
      end else if (w_clear) begin
        r_instruction <= INSTRUCTION'(NOP_INSTR);
        r_pc          <= r_pc;
        r_if_valid    <= 1'b0;
      end else begin
        r_instruction <= r_instruction;
        r_pc          <= r_pc;
        r_if_valid    <= r_if_valid;
      end
    end
  end

  assign imem_req    = w_req & ~rst;
  assign imem_addr   = w_fetch_pc;
  assign instruction = r_instruction;
  assign pc          = r_pc;
  assign if_valid    = r_if_valid;

endmodule
